// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int   BYTES_PER_WORD = 4;
  localparam logic OWN_IF         = 1'b0;
  localparam logic OWN_D          = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and byte-memory bus bundle for the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              if_stall;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ready;
  logic              d_stall;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [7:0]        m_wdata;
  logic [7:0]        m_rdata;

  // The arbiter itself takes the slave side; pipeline and memory sit on master.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           m_addr, m_we, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           m_addr, m_we, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - two-requester round-robin with a stored last-served flag
module rr_arb2
  import pipe_pkg::*;
#(
  parameter bit RESET_PRIO_D = 1'b1
) (
  input  logic       clk,
  input  logic       res,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (update) last_d = last;
  end

  // Reset so that the first contention favours the RESET_PRIO_D port.
  always_ff @(posedge clk or negedge res) begin
    if (!res) last_q <= ~RESET_PRIO_D;
    else      last_q <= last_d;
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == OWN_D) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises 32-bit fetch and load/store accesses onto a byte-wide memory
module mem_port_arbiter
  import pipe_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter bit RESET_PRIO_D = 1'b1
) (
  input  logic              clk,
  input  logic              res,
  mem_port_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [1:0]        arb_req, arb_grant;
  logic              arb_update;
  logic              m_we;
  logic [7:0]        wbyte;
  logic              unused_addr_bits;

  assign arb_req = {bus.d_req, bus.if_req};

  rr_arb2 #(.RESET_PRIO_D(RESET_PRIO_D)) u_arb (
    .clk    (clk),
    .res    (res),
    .req    (arb_req),
    .update (arb_update),
    .last   (arb_grant[1]),
    .grant  (arb_grant)
  );

  always_comb begin
    wbyte = 8'h00;
    case (cnt_q)
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    owner_d    = owner_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    arb_update = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_req) begin
          arb_update = 1'b1;
          cnt_d      = 2'd0;
          state_d    = XFER;
          if (arb_grant[1]) begin
            owner_d = OWN_D;
            base_d  = bus.d_addr[ADDR_W-1:0];
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
          end else begin
            owner_d = OWN_IF;
            base_d  = bus.if_addr[ADDR_W-1:0];
            we_d    = 1'b0;
            wdata_d = 32'h0;
          end
        end
      end
      XFER: begin
        // Read data trails its address by one cycle, so byte cnt-1 lands now.
        if (!we_q) begin
          case (cnt_q)
            2'd1:    word_d[7:0]   = bus.m_rdata;
            2'd2:    word_d[15:8]  = bus.m_rdata;
            2'd3:    word_d[23:16] = bus.m_rdata;
            default: ;
          endcase
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
          if (we_q) begin
            state_d = DONE;
            if (owner_q == OWN_D) d_ready_d  = 1'b1;
            else                  if_ready_d = 1'b1;
          end else begin
            state_d = RWAIT;
          end
        end
      end
      RWAIT: begin
        state_d = DONE;
        if (owner_q == OWN_D) begin
          d_rdata_d = {bus.m_rdata, word_q};
          d_ready_d = 1'b1;
        end else begin
          if_rdata_d = {bus.m_rdata, word_q};
          if_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      base_q     <= '0;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      word_q     <= 24'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
    end
  end

  // Write strobe decoded from state so reset removes it without waiting a clock.
  assign m_we         = (state_q == XFER) && we_q;
  assign bus.m_we     = m_we;
  assign bus.m_addr   = base_q + ADDR_W'(cnt_q);
  assign bus.m_wdata  = m_we ? wbyte : 8'h00;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.if_ready = if_ready_q;
  assign bus.d_ready  = d_ready_q;
  assign bus.if_stall = bus.if_req & ~if_ready_q;
  assign bus.d_stall  = bus.d_req & ~d_ready_q;

  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W], bus.d_addr[31:ADDR_W]};

endmodule
